// File: rtl/axi_mem_sub.sv
// rtl/axi_mem_sub.sv - single-beat AXI subordinate memory with independent read and write FSMs
package axi_mem_sub_pkg;
    typedef struct packed { logic [3:0] id; logic [31:0] addr; logic [7:0] len; } axi_aw_t;
    typedef struct packed { logic [63:0] data; logic [7:0] strb; } axi_w_t;
    typedef struct packed { logic [3:0] id; logic [1:0] resp; } axi_b_t;
    typedef struct packed { logic [3:0] id; logic [31:0] addr; logic [7:0] len; } axi_ar_t;
    typedef struct packed { logic [3:0] id; logic [63:0] data; logic [1:0] resp; logic last; } axi_r_t;
endpackage

module axi_mem_sub
    import axi_mem_sub_pkg::*;
#(
    parameter int DEPTH        = 1024,
    parameter int READ_LATENCY = 1
) (
    input  logic    clk,
    input  logic    rst,
    input  axi_aw_t i_axi_s_aw,
    input  logic    i_axi_s_awvalid,
    output logic    o_axi_s_awready,
    input  axi_w_t  i_axi_s_w,
    input  logic    i_axi_s_wvalid,
    output logic    o_axi_s_wready,
    output axi_b_t  o_axi_s_b,
    output logic    o_axi_s_bvalid,
    input  logic    i_axi_s_bready,
    input  axi_ar_t i_axi_s_ar,
    input  logic    i_axi_s_arvalid,
    output logic    o_axi_s_arready,
    output axi_r_t  o_axi_s_r,
    output logic    o_axi_s_rvalid,
    input  logic    i_axi_s_rready
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;

    function automatic logic req_ok(input logic [31:0] addr, input logic [7:0] len);
        return ((addr >> (AW + 3)) == 32'd0) && (len == 8'd0);
    endfunction

    // Contents survive reset; only the power-up value is defined.
    logic [63:0] r_mem [DEPTH] = '{default: '0};

    w_state_t r_wstate, w_wstate_nxt;
    logic     r_awready, r_wready, r_aw_got, r_w_got, r_bvalid;
    axi_aw_t  r_aw;
    axi_w_t   r_w;
    axi_b_t   r_b;
    logic     w_aw_hs, w_w_hs, w_commit, w_wr_ok;
    axi_aw_t  w_aw;
    axi_w_t   w_w;
    logic [AW-1:0] w_wr_idx;

    assign w_aw_hs  = i_axi_s_awvalid & r_awready;
    assign w_w_hs   = i_axi_s_wvalid & r_wready;
    assign w_aw     = r_aw_got ? r_aw : i_axi_s_aw;
    assign w_w      = r_w_got ? r_w : i_axi_s_w;
    assign w_commit = (r_wstate == W_IDLE) & (r_aw_got | w_aw_hs) & (r_w_got | w_w_hs);
    assign w_wr_ok  = req_ok(w_aw.addr, w_aw.len);
    assign w_wr_idx = w_aw.addr[3 +: AW];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_wstate <= W_IDLE;
        else     r_wstate <= w_wstate_nxt;
    end

    always_comb begin
        w_wstate_nxt = r_wstate;
        case (r_wstate)
            W_IDLE:  if (w_commit) w_wstate_nxt = W_RESP;
            W_RESP:  if (i_axi_s_bready) w_wstate_nxt = W_IDLE;
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_aw_got  <= 1'b0;
            r_w_got   <= 1'b0;
            r_bvalid  <= 1'b0;
            r_aw      <= '0;
            r_w       <= '0;
            r_b       <= '0;
        end else if (r_wstate == W_IDLE) begin
            if (w_commit) begin
                r_awready <= 1'b0;
                r_wready  <= 1'b0;
                r_aw_got  <= 1'b0;
                r_w_got   <= 1'b0;
                r_bvalid  <= 1'b1;
                r_b       <= '{id: w_aw.id, resp: (w_wr_ok ? 2'b00 : 2'b10)};
            end else begin
                if (w_aw_hs) r_aw <= i_axi_s_aw;
                if (w_w_hs)  r_w  <= i_axi_s_w;
                r_aw_got  <= r_aw_got | w_aw_hs;
                r_w_got   <= r_w_got | w_w_hs;
                r_awready <= ~(r_aw_got | w_aw_hs);
                r_wready  <= ~(r_w_got | w_w_hs);
            end
        end else if (i_axi_s_bready) begin
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
        end
    end

    always @(posedge clk) begin
        if (!rst && w_commit && w_wr_ok) begin
            for (int i = 0; i < 8; i++) begin
                if (w_w.strb[i]) r_mem[w_wr_idx][8*i +: 8] <= w_w.data[8*i +: 8];
            end
        end
    end

    r_state_t r_rstate, w_rstate_nxt;
    logic     r_arready, r_rvalid;
    axi_ar_t  r_ar;
    axi_r_t   r_r;
    logic [3:0] r_cnt;
    logic     w_ar_hs, w_rd_ok;

    assign w_ar_hs = i_axi_s_arvalid & r_arready;
    assign w_rd_ok = req_ok(r_ar.addr, r_ar.len);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_rstate <= R_IDLE;
        else     r_rstate <= w_rstate_nxt;
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_WAIT;
            R_WAIT:  if (r_cnt == 4'd0) w_rstate_nxt = R_RESP;
            R_RESP:  if (i_axi_s_rready) w_rstate_nxt = R_IDLE;
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    // The memory read here sees pre-write contents when a write commits on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_ar      <= '0;
            r_r       <= '0;
            r_cnt     <= '0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_ar      <= i_axi_s_ar;
                        r_arready <= 1'b0;
                        r_cnt     <= 4'(READ_LATENCY - 1);
                    end else begin
                        r_arready <= 1'b1;
                    end
                end
                R_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_rvalid <= 1'b1;
                        r_r      <= '{id: r_ar.id,
                                      data: (w_rd_ok ? r_mem[r_ar.addr[3 +: AW]] : 64'd0),
                                      resp: (w_rd_ok ? 2'b00 : 2'b10),
                                      last: 1'b1};
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                R_RESP: begin
                    if (i_axi_s_rready) begin
                        r_rvalid  <= 1'b0;
                        r_arready <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_axi_s_awready = r_awready;
    assign o_axi_s_wready  = r_wready;
    assign o_axi_s_b       = r_b;
    assign o_axi_s_bvalid  = r_bvalid;
    assign o_axi_s_arready = r_arready;
    assign o_axi_s_r       = r_r;
    assign o_axi_s_rvalid  = r_rvalid;
endmodule

// File: doc/axi_mem_sub.md
AXI_MEM_SUB -- requirements
Module: axi_mem_sub

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, meaning number of 64-bit memory words (power of two).
REQ-002 SHALL have parameter READ_LATENCY, default 1, meaning cycles from AR handshake to rvalid (legal 1..15).
REQ-003 SHALL have one clock and an asynchronous, active-high reset: clk input 1 (rising-edge clock); rst input 1 (async reset, active-high).
REQ-004 SHALL have the following ports, each as name, direction, width, meaning:
- i_axi_s_aw input axi_aw_t: write address.
- i_axi_s_awvalid input 1.
- o_axi_s_awready output 1.
- i_axi_s_w input axi_w_t: write data.
- i_axi_s_wvalid input 1.
- o_axi_s_wready output 1.
- o_axi_s_b output axi_b_t: write response (id, resp).
- o_axi_s_bvalid output 1.
- i_axi_s_bready input 1.
- i_axi_s_ar input axi_ar_t: read address.
- i_axi_s_arvalid input 1.
- o_axi_s_arready output 1.
- o_axi_s_r output axi_r_t: read data (id, data, resp, last).
- o_axi_s_rvalid output 1.
- i_axi_s_rready input 1.

Function
REQ-005 SHALL be an AXI subordinate: single-beat memory; all ready/valid outputs registered.
REQ-006 SHALL compute word index = addr[3 +: log2(DEPTH)].
- Byte address >= DEPTH*8 is out of range.
REQ-007 SHALL run read and write FSMs independently, each with at most one transaction outstanding.
REQ-008 Write FSM SHALL have states W_IDLE, W_RESP.
- In W_IDLE, awready=1 until AW is captured and wready=1 until W is captured, in either order, any gap, or the same cycle.
REQ-009 On the edge where AW and W are both held, SHALL commit the write bytewise per strb.
- On that same edge: set bvalid=1, drive b.id=aw.id, clear both readies, enter W_RESP.
REQ-010 In W_RESP, SHALL hold bvalid and b stable until bready.
- On the bvalid&bready edge: bvalid=0, readies=1, return to W_IDLE.
REQ-011 Read FSM SHALL have states R_IDLE, R_WAIT, R_RESP.
- R_IDLE: arready=1. On AR handshake: latch id/addr/len, arready=0, load counter with READ_LATENCY-1, go to R_WAIT.
REQ-012 In R_WAIT, SHALL decrement the counter each cycle.
- At 0: load r.data from memory, set rvalid=1, last=1, r.id=ar.id, go to R_RESP.
- rvalid therefore rises exactly READ_LATENCY edges after the AR handshake edge.
REQ-013 In R_RESP, SHALL hold r stable until rready.
- On the rvalid&rready edge: rvalid=0, arready=1, go to R_IDLE.
REQ-014 resp SHALL be OKAY (2'b00) for in-range, len==0 requests.
- Out-of-range or len!=0 SHALL return SLVERR (2'b10) with no memory update; read data=0, last=1.
REQ-015 A read loading data on the same edge a write commits to the same word SHALL return the pre-write data.
REQ-016 Memory contents SHALL be initialised to zero at time 0 and SHALL NOT be cleared by reset.

Reset
REQ-017 While rst=1, SHALL force all ready/valid outputs to 0 and both FSMs to their IDLE states.
- SHALL discard captured AW/W and in-flight reads; b and r payloads go to 0.
REQ-018 On the first clk edge after rst deasserts, SHALL set awready, wready and arready to 1.
REQ-019 Reset asserted mid-transaction SHALL abort it.
- A write commits only if its commit edge precedes reset.

Verification
REQ-020 Write addr 0x8, data 0x1122334455667788, strb 0xFF, AW and W in the same cycle -> bvalid on next edge, resp 0. Then read 0x8 -> data 0x1122334455667788, rvalid 1 cycle after AR.
REQ-021 AW id 3 addr 0x10, W issued 15 cycles later with strb 0x0F, data 0xFFFFFFFFFFFFFFFF -> wready held 1 throughout, single commit, b.id=3. Readback 0x00000000FFFFFFFF.
REQ-022 READ_LATENCY=4, rready held 0 for 5 cycles -> rvalid rises 4 edges after AR, data/id stable, no second AR accepted until handshake.
REQ-023 Read addr DEPTH*8 and write with len=2 -> both resp 2'b10, memory unchanged, r.data 0, last 1.
REQ-024 Assert rst while in R_WAIT and while holding AW without W -> all valids 0 immediately; readies 1 one edge after release; subsequent transactions complete normally; no stray write.
REQ-025 Same-edge write commit and read load to 0x20 (old 0xA, new 0xB) -> read returns 0xA; next read returns 0xB.
